// File: rtl/instruction_fetch_unit_pkg.sv
// Shared RISC-V core definitions used by the fetch front end.
package rv_core_pkg;

  localparam int XLEN       = 64;
  localparam int ILEN       = 32;
  localparam int INST_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic is_inst_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} pairs with flush and a
// registered head entry so decode sees glitch-free outputs.
import rv_core_pkg::*;

module fetch_queue #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wr_entry,
  output logic         full,
  output logic         vld_p1,
  output fetch_entry_t head_entry_p1
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_next;
  logic [CNT_W-1:0] count_q, cnt_after_pop;
  logic             do_pop, do_push;
  logic             head_vld_nxt;
  fetch_entry_t     head_nxt;

  assign full    = (count_q == FULL_CNT);
  assign do_pop  = pop & vld_p1 & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  // Next head is chosen ahead of the edge so the head can be a plain register;
  // an empty queue bypasses the incoming word straight to the head.
  always_comb begin
    cnt_after_pop = count_q - CNT_W'(do_pop);
    rd_next       = rd_ptr + PTR_W'(do_pop);
    head_vld_nxt  = 1'b0;
    head_nxt      = '0;
    if (cnt_after_pop == '0) begin
      head_vld_nxt = do_push;
      head_nxt     = do_push ? wr_entry : '0;
    end else begin
      head_vld_nxt = 1'b1;
      head_nxt     = mem[rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

  // ---- stage p1: queue control and registered head ----
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count_q       <= '0;
      vld_p1        <= 1'b0;
      head_entry_p1 <= '0;
    end else begin
      rd_ptr        <= rd_next;
      wr_ptr        <= wr_ptr + PTR_W'(do_push);
      count_q       <= cnt_after_pop + CNT_W'(do_push);
      vld_p1        <= head_vld_nxt;
      head_entry_p1 <= head_nxt;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the PC, drives instruction memory, and queues
// fetched words toward decode; redirects flush and reload the PC.
import rv_core_pkg::*;

module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] Inst_Address,
  input  logic [31:0] Instruction,
  input  logic        Branch_Taken,
  input  logic [63:0] Branch_Target,
  output logic        Inst_Valid,
  input  logic        Inst_Ready,
  output logic [31:0] Inst_Out,
  output logic [63:0] Inst_PC,
  output logic        Fetch_Misaligned
);

  logic [63:0]  pc_p0;
  logic         halted_p0;
  logic         misaligned_p0;
  logic         q_full;
  logic         pop, push;
  fetch_entry_t wr_entry;
  fetch_entry_t head_entry_p1;

  assign Inst_Address     = pc_p0;
  assign Fetch_Misaligned = misaligned_p0;

  // A redirect owns the cycle: any handshake decode attempts is discarded.
  assign pop  = Inst_Valid & Inst_Ready & ~Branch_Taken;
  assign push = ~Branch_Taken & ~halted_p0 & (~q_full | pop);

  assign wr_entry = '{pc: pc_p0, instr: Instruction};

  // ---- stage p0: program counter and redirect/halt state ----
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0         <= RESET_PC;
      halted_p0     <= 1'b0;
      misaligned_p0 <= 1'b0;
    end else if (Branch_Taken) begin
      pc_p0         <= Branch_Target;
      halted_p0     <= ~is_inst_aligned(Branch_Target);
      misaligned_p0 <= ~is_inst_aligned(Branch_Target);
    end else if (push) begin
      pc_p0         <= pc_p0 + 64'(INST_BYTES);
    end
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_fetch_queue (
    .clk          (clk),
    .reset        (reset),
    .flush        (Branch_Taken),
    .push         (push),
    .pop          (pop),
    .wr_entry     (wr_entry),
    .full         (q_full),
    .vld_p1       (Inst_Valid),
    .head_entry_p1(head_entry_p1)
  );

  assign Inst_Out = head_entry_p1.instr;
  assign Inst_PC  = head_entry_p1.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed scoreboard bench for instruction_fetch_unit.
module tb_instruction_fetch_unit;
  import rv_core_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset1, bt1, ready1;
  logic [63:0] tgt1, addr1, ipc1;
  logic [31:0] instr1, iout1;
  logic        valid1, mis1;

  logic        reset2, bt2, ready2;
  logic [63:0] tgt2, addr2, ipc2;
  logic [31:0] instr2, iout2;
  logic        valid2, mis2;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  fetch_entry_t sb[$];

  function automatic logic [31:0] imem(input logic [63:0] a);
    case (a[3:2])
      2'd0: return 32'h02853483;
      2'd1: return 32'h009A84B3;
      2'd2: return 32'h00148493;
      default: return 32'h02953423;
    endcase
  endfunction

  assign instr1 = imem(addr1);
  assign instr2 = imem(addr2);

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset1), .Inst_Address(addr1), .Instruction(instr1),
    .Branch_Taken(bt1), .Branch_Target(tgt1), .Inst_Valid(valid1),
    .Inst_Ready(ready1), .Inst_Out(iout1), .Inst_PC(ipc1), .Fetch_Misaligned(mis1)
  );

  instruction_fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .DEPTH(2)) dut_wrap (
    .clk(clk), .reset(reset2), .Inst_Address(addr2), .Instruction(instr2),
    .Branch_Taken(bt2), .Branch_Target(tgt2), .Inst_Valid(valid2),
    .Inst_Ready(ready2), .Inst_Out(iout2), .Inst_PC(ipc2), .Fetch_Misaligned(mis2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_fetch(input logic [63:0] pc);
    sb.push_back('{pc: pc, instr: imem(pc)});
  endtask

  // Observe the handshake just before the edge, then advance one cycle.
  task automatic tick();
    fetch_entry_t e;
    #1;
    if (!reset1 && !bt1 && valid1 && ready1) begin
      total++;
      assert (sb.size() != 0) passed++;
      else begin
        fails++;
        $error("FAIL unexpected_pop observed pc=%h expected no handshake", ipc1);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_pc", ipc1, e.pc);
        check("sb_instr", 64'(iout1), 64'(e.instr));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset1 = 1'b1; bt1 = 1'b0; tgt1 = '0; ready1 = 1'b1;
    reset2 = 1'b1; bt2 = 1'b0; tgt2 = '0; ready2 = 1'b0;
    @(negedge clk);
    tick();

    // Reset state
    check("rst_valid", 64'(valid1), 64'd0);
    check("rst_out", 64'(iout1), 64'd0);
    check("rst_pc", ipc1, 64'd0);
    check("rst_addr", addr1, 64'd0);
    check("rst_mis", 64'(mis1), 64'd0);

    // Streaming at one instruction per cycle
    reset1 = 1'b0;
    expect_fetch(64'h0); expect_fetch(64'h4); expect_fetch(64'h8); expect_fetch(64'hC);
    tick();
    check("lat_valid", 64'(valid1), 64'd1);
    for (int i = 0; i < 4; i++) tick();
    check("stream_drained", 64'(sb.size()), 64'd0);

    // Backpressure saturates the queue
    reset1 = 1'b1; ready1 = 1'b0;
    tick();
    reset1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp_head_pc", ipc1, 64'h0);
    end
    check("bp_addr", addr1, 64'h8);
    check("bp_valid", 64'(valid1), 64'd1);
    check("bp_out", 64'(iout1), 64'h02853483);
    ready1 = 1'b1;
    expect_fetch(64'h0); expect_fetch(64'h4); expect_fetch(64'h8);
    for (int i = 0; i < 3; i++) tick();
    ready1 = 1'b0;
    tick();
    check("bp_drained", 64'(sb.size()), 64'd0);

    // Redirect to 0xC while full
    bt1 = 1'b1; tgt1 = 64'hC; ready1 = 1'b1;
    tick();
    bt1 = 1'b0;
    check("br_bubble", 64'(valid1), 64'd0);
    check("br_addr", addr1, 64'hC);
    expect_fetch(64'hC);
    tick();
    check("br_valid", 64'(valid1), 64'd1);
    tick();
    ready1 = 1'b0;
    check("br_drained", 64'(sb.size()), 64'd0);

    // Misaligned redirect halts fetch
    bt1 = 1'b1; tgt1 = 64'h6; ready1 = 1'b1;
    tick();
    bt1 = 1'b0;
    check("mis_flag", 64'(mis1), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check("mis_valid", 64'(valid1), 64'd0);
      check("mis_addr", addr1, 64'h6);
      tick();
    end
    bt1 = 1'b1; tgt1 = 64'h4;
    tick();
    bt1 = 1'b0;
    check("realign_flag", 64'(mis1), 64'd0);
    check("realign_bubble", 64'(valid1), 64'd0);
    expect_fetch(64'h4);
    tick();
    check("realign_valid", 64'(valid1), 64'd1);
    check("realign_pc", ipc1, 64'h4);
    tick();
    ready1 = 1'b0;
    check("realign_drained", 64'(sb.size()), 64'd0);

    // Reset with a full queue, colliding with a misaligned redirect
    tick(); tick(); tick();
    check("pre_rst_valid", 64'(valid1), 64'd1);
    reset1 = 1'b1; bt1 = 1'b1; tgt1 = 64'h6; ready1 = 1'b1;
    tick();
    check("mid_rst_valid", 64'(valid1), 64'd0);
    check("mid_rst_addr", addr1, 64'h0);
    check("mid_rst_mis", 64'(mis1), 64'd0);
    check("mid_rst_pc", ipc1, 64'h0);
    check("mid_rst_out", 64'(iout1), 64'd0);
    reset1 = 1'b0; bt1 = 1'b0;
    expect_fetch(64'h0);
    tick();
    tick();
    ready1 = 1'b0;
    check("post_rst_drained", 64'(sb.size()), 64'd0);

    // PC wrap-around from the top of the address space
    check("wrap_rst_addr", addr2, 64'hFFFF_FFFF_FFFF_FFFC);
    reset2 = 1'b0; ready2 = 1'b1;
    tick();
    check("wrap_addr", addr2, 64'h0);
    check("wrap_head_pc", ipc2, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_head_out", 64'(iout2), 64'h02953423);
    tick();
    check("wrap_next_pc", ipc2, 64'h0);
    check("wrap_next_out", 64'(iout2), 64'h02853483);
    check("wrap_next_addr", addr2, 64'h4);
    tick();
    check("wrap_third_pc", ipc2, 64'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
